// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//   Shared encodings for the pipeline hazard controller. It holds the EX
//   operand-forwarding select codes, the sequencing FSM state encodings and
//   a helper that picks the forwarding source for one EX operand.
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    // EX operand source select
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file value
        FWD_WB  = 2'b01,   // result currently in WB
        FWD_MEM = 2'b10    // result currently in MEM
    } fwd_sel_t;

    // Sequencing FSM
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HOLD = 2'b01,
        ERR  = 2'b10
    } ctrl_state_t;

    // Forwarding source for one EX source register. The younger MEM result
    // wins over WB. x0 is never forwarded because it is hard-wired to zero.
    function automatic fwd_sel_t fwd_select(
        input logic [REG_W-1:0] src,
        input logic             mem_regwrite,
        input logic [REG_W-1:0] mem_rd,
        input logic             wb_regwrite,
        input logic [REG_W-1:0] wb_rd
    );
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) return FWD_MEM;
        if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))    return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Event counter that counts up by one while inc is high and sticks at
//   all-ones instead of wrapping.
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous, active-high reset (clears q)
//   inc  in   count this cycle
//   q    out  CNT_W-bit count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage pipeline. It produces
//   the stall/flush controls for PC, IF/ID and ID/EX and the EX operand
//   forwarding selects. It also produces a global hold while a data-memory
//   access is pending, and it moves to a sticky error state when the wait
//   lasts too long. Three saturating counters record hold cycles, load-use
//   bubbles and redirects.
// Parameters:
//   MEM_TIMEOUT  consecutive dmem wait cycles tolerated in HOLD (0 = never time out)
//   CNT_W        performance counter width
// Ports:
//   clk, rst                     clock / async active-high reset
//   id_rs1, id_rs2               ID source registers
//   id_use_rs1, id_use_rs2       ID instruction really reads rs1 / rs2
//   ex_rs1, ex_rs2, ex_rd        EX source and destination registers
//   ex_memread                   EX instruction is a load
//   ex_redirect                  branch taken / jump resolved in EX
//   mem_rd, mem_regwrite         MEM destination / write enable
//   wb_rd, wb_regwrite           WB destination / write enable
//   dmem_req, dmem_ready         data-memory access pending / completing
//   pc_stall, if_id_stall        PC and IF/ID hold
//   if_id_flush, id_ex_flush     load zeros into IF/ID, ID/EX
//   id_ex_stall                  ID/EX takes a bubble
//   npc_redirect                 PC takes the EX target
//   pipe_hold                    every stage register holds
//   fwd_a, fwd_b                 EX operand selects (fwd_sel_t codes)
//   mem_err                      sticky memory timeout error
//   cnt_hold, cnt_bubble, cnt_flush  saturating event counters
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             npc_redirect,
    output logic             pipe_hold,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_err,
    output logic [CNT_W-1:0] cnt_hold,
    output logic [CNT_W-1:0] cnt_bubble,
    output logic [CNT_W-1:0] cnt_flush
);

    // The wait counter only has to reach MEM_TIMEOUT. It saturates, so it
    // cannot wrap when the timeout is disabled.
    localparam int                WAIT_W      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam bit                TIMEOUT_EN  = (MEM_TIMEOUT != 0);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_wait;
    logic              lduse;

    // A memory that is ready in the same cycle it is requested causes no wait.
    assign mem_wait = dmem_req & ~dmem_ready;

    // The load in EX writes a register that the ID instruction reads.
    assign lduse = ex_memread && (ex_rd != '0) &&
                   ((id_use_rs1 && (ex_rd == id_rs1)) ||
                    (id_use_rs2 && (ex_rd == id_rs2)));

    // -----------------------------------------------------------------------
    // Pipeline controls, highest priority first: ERR, memory wait, redirect,
    // load-use. A redirect wins over load-use because the ID instruction is
    // squashed anyway. A memory wait freezes EX, so a pending redirect is
    // presented again once the wait ends.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the branches, so no path
        // leaves one unassigned and no latch is inferred.
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        npc_redirect = 1'b0;
        pipe_hold    = 1'b0;
        fwd_a        = FWD_RF;
        fwd_b        = FWD_RF;

        if (!rst) begin
            if (state == ERR) begin
                pipe_hold = 1'b1;
            end else begin
                if (mem_wait) begin
                    pipe_hold = 1'b1;
                end else if (ex_redirect) begin
                    npc_redirect = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                end else if (lduse) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                end
                fwd_a = fwd_select(ex_rs1, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
                fwd_b = fwd_select(ex_rs2, mem_regwrite, mem_rd, wb_regwrite, wb_rd);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequencing FSM. wait_cnt holds the number of consecutive wait cycles
    // already seen. The timeout fires on the wait cycle after MEM_TIMEOUT
    // such cycles.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_wait) begin
                        state    <= HOLD;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                HOLD: begin
                    if (!mem_wait) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_VAL)) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // The controls above are mutually exclusive, so at most one counter
    // advances in any cycle.
    sat_counter #(.CNT_W(CNT_W)) u_cnt_hold (
        .clk (clk),
        .rst (rst),
        .inc (pipe_hold),
        .q   (cnt_hold)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_bubble (
        .clk (clk),
        .rst (rst),
        .inc (id_ex_stall),
        .q   (cnt_bubble)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk (clk),
        .rst (rst),
        .inc (npc_redirect),
        .q   (cnt_flush)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Two instances share one stimulus stream. The main instance uses a
//   timeout of 4 and 32-bit counters. The second instance has the timeout
//   disabled and 4-bit counters, so its counters reach saturation within a
//   short run. Expected values come from a small rule-level model: a
//   priority decision per cycle, a run-length count of consecutive memory
//   waits, and integer event totals clipped to the counter maximum.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int TO_M  = 4;
    localparam int CW_M  = 32;
    localparam int CW_S  = 4;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_memread;
        logic       ex_redirect;
        logic [4:0] mem_rd;
        logic       mem_regwrite;
        logic [4:0] wb_rd;
        logic       wb_regwrite;
        logic       dmem_req;
        logic       dmem_ready;
    } in_t;

    // Output vector: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
    //                 id_ex_flush, npc_redirect, pipe_hold, fwd_a, fwd_b}
    typedef struct {
        in_t         in;
        logic [10:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  cur = '0;

    logic            pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic            npc_redirect, pipe_hold, mem_err;
    logic [1:0]      fwd_a, fwd_b;
    logic [CW_M-1:0] cnt_hold, cnt_bubble, cnt_flush;

    logic            s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush;
    logic            s_npc_redirect, s_pipe_hold, s_mem_err;
    logic [1:0]      s_fwd_a, s_fwd_b;
    logic [CW_S-1:0] s_cnt_hold, s_cnt_bubble, s_cnt_flush;

    logic [10:0] outs_m, outs_s;
    assign outs_m = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                     npc_redirect, pipe_hold, fwd_a, fwd_b};
    assign outs_s = {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush,
                     s_npc_redirect, s_pipe_hold, s_fwd_a, s_fwd_b};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO_M), .CNT_W(CW_M)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
        .id_use_rs1(cur.id_use_rs1), .id_use_rs2(cur.id_use_rs2),
        .ex_rs1(cur.ex_rs1), .ex_rs2(cur.ex_rs2), .ex_rd(cur.ex_rd),
        .ex_memread(cur.ex_memread), .ex_redirect(cur.ex_redirect),
        .mem_rd(cur.mem_rd), .mem_regwrite(cur.mem_regwrite),
        .wb_rd(cur.wb_rd), .wb_regwrite(cur.wb_regwrite),
        .dmem_req(cur.dmem_req), .dmem_ready(cur.dmem_ready),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .npc_redirect(npc_redirect), .pipe_hold(pipe_hold),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .cnt_hold(cnt_hold), .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
    );

    pipe_hazard_ctrl #(.MEM_TIMEOUT(0), .CNT_W(CW_S)) dut_s (
        .clk(clk), .rst(rst),
        .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
        .id_use_rs1(cur.id_use_rs1), .id_use_rs2(cur.id_use_rs2),
        .ex_rs1(cur.ex_rs1), .ex_rs2(cur.ex_rs2), .ex_rd(cur.ex_rd),
        .ex_memread(cur.ex_memread), .ex_redirect(cur.ex_redirect),
        .mem_rd(cur.mem_rd), .mem_regwrite(cur.mem_regwrite),
        .wb_rd(cur.wb_rd), .wb_regwrite(cur.wb_regwrite),
        .dmem_req(cur.dmem_req), .dmem_ready(cur.dmem_ready),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
        .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush),
        .npc_redirect(s_npc_redirect), .pipe_hold(s_pipe_hold),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .mem_err(s_mem_err),
        .cnt_hold(s_cnt_hold), .cnt_bubble(s_cnt_bubble), .cnt_flush(s_cnt_flush)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit     m_err;
    int     m_consec;
    longint m_hold, m_bub, m_flush;
    longint s_hold, s_bub, s_flush;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic in_t mk(input int r1, input int r2, input int u1, input int u2,
                               input int xs1, input int xs2, input int xrd, input int xmr,
                               input int xrdr, input int mrd, input int mrw, input int wrd,
                               input int wrw, input int req, input int rdy);
        in_t v;
        v.id_rs1 = 5'(r1);    v.id_rs2 = 5'(r2);
        v.id_use_rs1 = 1'(u1); v.id_use_rs2 = 1'(u2);
        v.ex_rs1 = 5'(xs1);   v.ex_rs2 = 5'(xs2);   v.ex_rd = 5'(xrd);
        v.ex_memread = 1'(xmr); v.ex_redirect = 1'(xrdr);
        v.mem_rd = 5'(mrd);   v.mem_regwrite = 1'(mrw);
        v.wb_rd = 5'(wrd);    v.wb_regwrite = 1'(wrw);
        v.dmem_req = 1'(req); v.dmem_ready = 1'(rdy);
        return v;
    endfunction

    function automatic logic [1:0] fwd_of(input in_t v, input logic [4:0] src);
        if (v.mem_regwrite && v.mem_rd != 0 && v.mem_rd == src) return 2'b10;
        if (v.wb_regwrite && v.wb_rd != 0 && v.wb_rd == src)    return 2'b01;
        return 2'b00;
    endfunction

    // Expected control outputs from the priority rules.
    function automatic logic [10:0] expect_out(input bit err, input in_t v, input logic r);
        logic [10:0] e;
        bit w, lu;
        e = '0;
        if (r) return e;
        if (err) begin
            e[4] = 1'b1;
            return e;
        end
        w  = v.dmem_req && !v.dmem_ready;
        lu = v.ex_memread && v.ex_rd != 0 &&
             ((v.id_use_rs1 && v.ex_rd == v.id_rs1) || (v.id_use_rs2 && v.ex_rd == v.id_rs2));
        if (w)                  e[4] = 1'b1;
        else if (v.ex_redirect) begin e[8] = 1'b1; e[6] = 1'b1; e[5] = 1'b1; end
        else if (lu)            begin e[10] = 1'b1; e[9] = 1'b1; e[7] = 1'b1; end
        e[3:2] = fwd_of(v, v.ex_rs1);
        e[1:0] = fwd_of(v, v.ex_rs2);
        return e;
    endfunction

    function automatic longint satv(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_clear();
        m_err = 1'b0; m_consec = 0;
        m_hold = 0; m_bub = 0; m_flush = 0;
        s_hold = 0; s_bub = 0; s_flush = 0;
    endtask

    // Drive inputs; reset is asynchronous, so the model clears at once.
    task automatic apply(input in_t v, input logic r);
        cur = v;
        rst = r;
        if (r) model_clear();
    endtask

    task automatic check_model();
        logic [10:0] e, es;
        e  = expect_out(m_err, cur, rst);
        es = expect_out(1'b0, cur, rst);
        check("outs_main",  64'(outs_m),     64'(e));
        check("mem_err",    64'(mem_err),    64'(m_err));
        check("cnt_hold",   64'(cnt_hold),   64'(satv(m_hold, CW_M)));
        check("cnt_bubble", 64'(cnt_bubble), 64'(satv(m_bub, CW_M)));
        check("cnt_flush",  64'(cnt_flush),  64'(satv(m_flush, CW_M)));
        check("outs_sat",   64'(outs_s),     64'(es));
        check("s_mem_err",  64'(s_mem_err),  64'd0);
        check("s_cnt_hold",   64'(s_cnt_hold),   64'(satv(s_hold, CW_S)));
        check("s_cnt_bubble", 64'(s_cnt_bubble), 64'(satv(s_bub, CW_S)));
        check("s_cnt_flush",  64'(s_cnt_flush),  64'(satv(s_flush, CW_S)));
    endtask

    // Advance one clock and update the model from the inputs of that cycle.
    task automatic tick();
        logic [10:0] e, es;
        @(posedge clk);
        e  = expect_out(m_err, cur, rst);
        es = expect_out(1'b0, cur, rst);
        if (rst) begin
            model_clear();
        end else begin
            if (e[4])  m_hold++;
            if (e[7])  m_bub++;
            if (e[5])  m_flush++;
            if (es[4]) s_hold++;
            if (es[7]) s_bub++;
            if (es[5]) s_flush++;
            if (!m_err) begin
                if (cur.dmem_req && !cur.dmem_ready) begin
                    if (m_consec == TO_M) m_err = 1'b1;
                    m_consec++;
                end else begin
                    m_consec = 0;
                end
            end
        end
        #1;
    endtask

    task automatic cycle(input in_t v);
        apply(v, 1'b0);
        @(negedge clk);
        check_model();
        tick();
    endtask

    task automatic do_reset();
        apply('0, 1'b1);
        @(negedge clk);
        check_model();
        tick();
    endtask

    in_t  idle, lu, wt, v;
    vec_t vecs[13];
    int   n, holds;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle = '0;
        lu   = mk(5,0,1,0, 0,0,5,1,0, 0,0,0,0, 0,0);
        wt   = mk(0,0,0,0, 0,0,0,0,0, 0,0,0,0, 1,0);

        vecs[0]  = '{mk(5,0,1,0,  0,0,5,1,0,   0,0,0,0,   0,0), 11'b11010000000};
        vecs[1]  = '{mk(0,9,0,1,  0,0,9,1,0,   0,0,0,0,   0,0), 11'b11010000000};
        vecs[2]  = '{mk(5,0,0,0,  0,0,5,1,0,   0,0,0,0,   0,0), 11'b00000000000};
        vecs[3]  = '{mk(0,0,1,1,  0,0,0,1,0,   0,0,0,0,   0,0), 11'b00000000000};
        vecs[4]  = '{mk(5,0,1,0,  0,0,5,1,1,   0,0,0,0,   0,0), 11'b00101100000};
        vecs[5]  = '{mk(0,0,0,0,  7,3,0,0,0,   7,1,7,1,   0,0), 11'b00000001000};
        vecs[6]  = '{mk(0,0,0,0,  7,0,0,0,0,   0,1,7,1,   0,0), 11'b00000000100};
        vecs[7]  = '{mk(0,0,0,0,  0,0,0,0,0,   0,1,0,1,   0,0), 11'b00000000000};
        vecs[8]  = '{mk(0,0,0,0,  4,12,0,0,0, 12,1,12,1,  0,0), 11'b00000000010};
        vecs[9]  = '{mk(5,0,1,0,  0,0,5,1,0,   0,0,0,0,   1,1), 11'b11010000000};
        vecs[10] = '{mk(5,0,1,0,  0,0,5,1,1,   0,0,0,0,   1,0), 11'b00000010000};
        vecs[11] = '{mk(0,0,0,0,  0,0,0,0,1,   0,0,0,0,   0,0), 11'b00101100000};
        vecs[12] = '{mk(0,0,0,0,  9,9,0,0,0,   9,0,9,0,   0,0), 11'b00000000000};

        // Reset state: lduse and forwarding inputs present, yet outputs stay low.
        model_clear();
        apply(mk(5,0,1,0, 7,0,5,1,1, 7,1,0,0, 1,0), 1'b1);
        @(negedge clk);
        check("reset_outs", 64'(outs_m), 64'd0);
        check("reset_cnt",  64'({cnt_hold, cnt_bubble, cnt_flush}), 64'd0);
        check("reset_err",  64'(mem_err), 64'd0);
        tick();

        // Table-driven single-cycle vectors
        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].in, 1'b0);
            @(negedge clk);
            check_model();
            check($sformatf("vec%0d", i), 64'(outs_m), 64'(vecs[i].exp));
            tick();
        end

        // Load-use stalls one cycle and counts one bubble
        do_reset();
        cycle(lu);
        apply(idle, 1'b0);
        @(negedge clk);
        check("lduse_bubble_cnt", 64'(cnt_bubble), 64'd1);
        check("lduse_released",   64'(pc_stall),   64'd0);
        tick();

        // Redirect masks load-use
        do_reset();
        v = lu; v.ex_redirect = 1'b1;
        apply(v, 1'b0);
        @(negedge clk);
        check("redir_ctrl", 64'({npc_redirect, if_id_flush, id_ex_flush, pc_stall, if_id_stall, id_ex_stall}),
              64'b111000);
        tick();
        apply(idle, 1'b0);
        @(negedge clk);
        check("redir_cnts", 64'({cnt_flush[7:0], cnt_bubble[7:0]}), 64'h0100);
        tick();

        // Three wait cycles, then ready
        do_reset();
        holds = 0;
        for (int i = 0; i < 3; i++) begin
            apply(wt, 1'b0);
            @(negedge clk);
            check_model();
            holds += int'(pipe_hold);
            tick();
        end
        v = wt; v.dmem_ready = 1'b1;
        apply(v, 1'b0);
        @(negedge clk);
        check("wait_ready_nohold", 64'(pipe_hold), 64'd0);
        tick();
        apply(lu, 1'b0);
        @(negedge clk);
        check("wait_hold_cycles", 64'(holds), 64'd3);
        check("wait_cnt_hold",    64'(cnt_hold), 64'd3);
        check("wait_back_to_run", 64'({pipe_hold, pc_stall, mem_err}), 64'b010);
        tick();

        // Timeout: ERR entered on the wait cycle after TO_M consecutive waits
        do_reset();
        n = 0;
        while (!mem_err && n < 20) begin
            cycle(wt);
            n++;
        end
        check("timeout_edges", 64'(n), 64'(TO_M + 1));
        v = mk(0,0,0,0, 7,7,0,0,0, 7,1,0,0, 0,1);
        for (int i = 0; i < 3; i++) begin
            apply(v, 1'b0);
            @(negedge clk);
            check_model();
            check("err_sticky", 64'({mem_err, pipe_hold, fwd_a, fwd_b}), 64'b110000);
            tick();
        end
        apply(v, 1'b1);
        #1;
        check("err_cleared_by_rst", 64'({mem_err, pipe_hold, cnt_hold[7:0]}), 64'd0);
        @(negedge clk);
        tick();
        cycle(v);

        // Asynchronous reset in the middle of HOLD
        do_reset();
        cycle(wt);
        cycle(wt);
        #2;
        apply(wt, 1'b1);
        #1;
        check("async_rst_outs", 64'(outs_m), 64'd0);
        check("async_rst_cnt",  64'({cnt_hold[7:0], s_cnt_hold}), 64'd0);
        @(negedge clk);
        tick();
        apply(idle, 1'b0);
        @(negedge clk);
        check("after_rst_run", 64'(pipe_hold), 64'd0);
        tick();
        cycle(wt);

        // 4-bit counter saturates at 15 and stays there
        do_reset();
        for (int i = 0; i < 20; i++) cycle(wt);
        apply(wt, 1'b0);
        @(negedge clk);
        check("sat_hold_15", 64'(s_cnt_hold), 64'd15);
        tick();
        apply(idle, 1'b0);
        @(negedge clk);
        check("sat_hold_nowrap", 64'(s_cnt_hold), 64'd15);
        tick();

        // Randomized segments; odd segments make long memory waits likely
        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            for (int c = 0; c < 250; c++) begin
                v.id_rs1       = 5'($urandom_range(0, 3));
                v.id_rs2       = 5'($urandom_range(0, 3));
                v.id_use_rs1   = 1'($urandom_range(0, 1));
                v.id_use_rs2   = 1'($urandom_range(0, 1));
                v.ex_rs1       = 5'($urandom_range(0, 3));
                v.ex_rs2       = 5'($urandom_range(0, 3));
                v.ex_rd        = 5'($urandom_range(0, 3));
                v.ex_memread   = ($urandom_range(0, 2) == 0);
                v.ex_redirect  = ($urandom_range(0, 7) == 0);
                v.mem_rd       = 5'($urandom_range(0, 3));
                v.mem_regwrite = 1'($urandom_range(0, 1));
                v.wb_rd        = 5'($urandom_range(0, 3));
                v.wb_regwrite  = 1'($urandom_range(0, 1));
                v.dmem_req     = 1'($urandom_range(0, 1));
                v.dmem_ready   = (seg % 2 == 0) ? 1'($urandom_range(0, 1))
                                                : ($urandom_range(0, 9) == 0);
                apply(v, ($urandom_range(0, 99) == 0));
                @(negedge clk);
                check_model();
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
